// File: rtl/dp_pkg.sv
// Shared types and constants for the datapath sequencer and its register file.
package dp_pkg;

  localparam int unsigned REG_IDX_W = 3;
  localparam int unsigned DW        = 8;
  localparam int unsigned NREG      = 8;

  localparam logic [3:0] OP_PASS    = 4'b0000;
  localparam logic [3:0] OP_ILLEGAL = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_WB
  } state_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  // Opcodes with the top select bit clear belong to the arithmetic group.
  function automatic logic is_arith(input logic [3:0] code);
    return ~code[3];
  endfunction

endpackage

// File: rtl/dp_regfile.sv
// 8x8 register file: two combinational read ports, one debug read port, one synchronous write.
// DP_REG0_ZERO_EN: when defined, r0 is hardwired to zero and writes to it are dropped.
module dp_regfile
  import dp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] ra_addr,
  input  logic [REG_IDX_W-1:0] rb_addr,
  input  logic [REG_IDX_W-1:0] dbg_addr,
  input  logic                 wr_en,
  input  logic [REG_IDX_W-1:0] wr_addr,
  input  logic [DW-1:0]        wr_data,
  output logic [DW-1:0]        ra_data,
  output logic [DW-1:0]        rb_data,
  output logic [DW-1:0]        dbg_data
);

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[wr_addr] = wr_data;
    end
`ifdef DP_REG0_ZERO_EN
    regs_d[0] = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign ra_data  = regs_q[ra_addr];
  assign rb_data  = regs_q[rb_addr];
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/datapath_sequencer.sv
// Micro-op sequencer: reads operands, drives the external function unit, writes back result/status.
// Optional build macro DP_REG0_ZERO_EN (handled in dp_regfile) makes r0 read as zero.
module datapath_sequencer
  import dp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [3:0]           op_code,
  input  logic [REG_IDX_W-1:0] op_dst,
  input  logic [REG_IDX_W-1:0] op_srca,
  input  logic [REG_IDX_W-1:0] op_srcb,
  input  logic                 op_imm_en,
  input  logic [DW-1:0]        op_imm,
  output logic [DW-1:0]        fu_a,
  output logic [DW-1:0]        fu_b,
  output logic                 fu_s2,
  output logic                 fu_s1,
  output logic                 fu_s0,
  output logic                 fu_cin,
  input  logic [DW-1:0]        fu_g,
  input  logic                 fu_n,
  input  logic                 fu_z,
  input  logic                 fu_c,
  input  logic                 fu_v,
  output logic                 done,
  output logic                 op_err,
  output logic [3:0]           status,
  input  logic [REG_IDX_W-1:0] dbg_addr,
  output logic [DW-1:0]        dbg_data
);

  state_e               state_q,    state_d;
  logic [REG_IDX_W-1:0] dst_q,      dst_d;
  logic [3:0]           code_q,     code_d;
  logic                 imm_en_q,   imm_en_d;
  logic [DW-1:0]        result_q,   result_d;
  flags_t               flags_q,    flags_d;
  flags_t               status_q,   status_d;
  logic [DW-1:0]        fu_a_q,     fu_a_d;
  logic [DW-1:0]        fu_b_q,     fu_b_d;
  logic [3:0]           fu_sel_q,   fu_sel_d;
  logic                 done_q,     done_d;
  logic                 op_err_q,   op_err_d;
  logic                 op_ready_q, op_ready_d;

  logic [DW-1:0] rd_a;
  logic [DW-1:0] rd_b;
  logic          wr_en;

  // op_err_q is only ever set in WB, so it doubles as the write-suppress for illegal ops.
  assign wr_en = (state_q == ST_WB) && !op_err_q;

  dp_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .ra_addr  (op_srca),
    .rb_addr  (op_srcb),
    .dbg_addr (dbg_addr),
    .wr_en    (wr_en),
    .wr_addr  (dst_q),
    .wr_data  (result_q),
    .ra_data  (rd_a),
    .rb_data  (rd_b),
    .dbg_data (dbg_data)
  );

  always_comb begin
    state_d  = state_q;
    dst_d    = dst_q;
    code_d   = code_q;
    imm_en_d = imm_en_q;
    result_d = result_q;
    flags_d  = flags_q;
    status_d = status_q;
    fu_a_d   = fu_a_q;
    fu_b_d   = fu_b_q;
    fu_sel_d = fu_sel_q;
    done_d   = 1'b0;
    op_err_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          dst_d    = op_dst;
          code_d   = op_code;
          imm_en_d = op_imm_en;
          if (op_imm_en) begin
            result_d   = op_imm;
            flags_d.n  = op_imm[DW-1];
            flags_d.z  = (op_imm == '0);
            state_d    = ST_WB;
            done_d     = 1'b1;
          end else begin
            fu_a_d   = rd_a;
            fu_b_d   = rd_b;
            fu_sel_d = op_code;
            state_d  = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        result_d = fu_g;
        flags_d  = '{n: fu_n, z: fu_z, c: fu_c, v: fu_v};
        state_d  = ST_WB;
        done_d   = 1'b1;
        op_err_d = (code_q == OP_ILLEGAL);
      end
      ST_WB: begin
        state_d = ST_IDLE;
        if (!op_err_q) begin
          status_d.n = flags_q.n;
          status_d.z = flags_q.z;
          if (!imm_en_q && is_arith(code_q)) begin
            status_d.c = flags_q.c;
            status_d.v = flags_q.v;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    op_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      dst_q      <= '0;
      code_q     <= '0;
      imm_en_q   <= 1'b0;
      result_q   <= '0;
      flags_q    <= '0;
      status_q   <= '0;
      fu_a_q     <= '0;
      fu_b_q     <= '0;
      fu_sel_q   <= '0;
      done_q     <= 1'b0;
      op_err_q   <= 1'b0;
      op_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      dst_q      <= dst_d;
      code_q     <= code_d;
      imm_en_q   <= imm_en_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
      status_q   <= status_d;
      fu_a_q     <= fu_a_d;
      fu_b_q     <= fu_b_d;
      fu_sel_q   <= fu_sel_d;
      done_q     <= done_d;
      op_err_q   <= op_err_d;
      op_ready_q <= op_ready_d;
    end
  end

  assign op_ready = op_ready_q;
  assign done     = done_q;
  assign op_err   = op_err_q;
  assign status   = status_q;
  assign fu_a     = fu_a_q;
  assign fu_b     = fu_b_q;
  assign {fu_s2, fu_s1, fu_s0, fu_cin} = fu_sel_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer with a behavioural function unit and reference model.
module tb_datapath_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       op_valid;
  logic       op_ready;
  logic [3:0] op_code;
  logic [2:0] op_dst, op_srca, op_srcb;
  logic       op_imm_en;
  logic [7:0] op_imm;
  logic [7:0] fu_a, fu_b, fu_g;
  logic       fu_s2, fu_s1, fu_s0, fu_cin;
  logic       fu_n, fu_z, fu_c, fu_v;
  logic       done, op_err;
  logic [3:0] status;
  logic [2:0] dbg_addr;
  logic [7:0] dbg_data;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] m_regs [8];
  logic [3:0] m_status;

  always #5 clk = ~clk;

  datapath_sequencer dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .op_dst(op_dst), .op_srca(op_srca), .op_srcb(op_srcb), .op_imm_en(op_imm_en),
    .op_imm(op_imm), .fu_a(fu_a), .fu_b(fu_b), .fu_s2(fu_s2), .fu_s1(fu_s1), .fu_s0(fu_s0),
    .fu_cin(fu_cin), .fu_g(fu_g), .fu_n(fu_n), .fu_z(fu_z), .fu_c(fu_c), .fu_v(fu_v),
    .done(done), .op_err(op_err), .status(status), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Function unit: S2=0 arithmetic A + {0,B,~B,FF} + Cin; S2=1 logic AND/OR/XOR/NOT A.
  function automatic logic [11:0] fu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] code);
    logic [8:0] s;
    logic [7:0] bb, g;
    logic       c, v;
    c = 1'b0; v = 1'b0; bb = 8'h00; g = 8'h00;
    case (code[3:1])
      3'd0: bb = 8'h00;
      3'd1: bb = b;
      3'd2: bb = ~b;
      3'd3: bb = 8'hFF;
      3'd4: g = a & b;
      3'd5: g = a | b;
      3'd6: g = a ^ b;
      default: g = ~a;
    endcase
    if (!code[3]) begin
      s = {1'b0, a} + {1'b0, bb} + {8'd0, code[0]};
      g = s[7:0];
      c = s[8];
      v = (a[7] == bb[7]) && (g[7] != a[7]);
    end
    return {g, g[7], (g == 8'h00), c, v};
  endfunction

  always_comb {fu_g, fu_n, fu_z, fu_c, fu_v} = fu_model(fu_a, fu_b, {fu_s2, fu_s1, fu_s0, fu_cin});

  function automatic logic [7:0] m_rd(input logic [2:0] idx);
`ifdef DP_REG0_ZERO_EN
    if (idx == 3'd0) return 8'h00;
`endif
    return m_regs[idx];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_status = 4'h0;
  endtask

  task automatic m_apply(input logic ie, input logic [3:0] code, input logic [2:0] dst,
                         input logic [2:0] sa, input logic [2:0] sb, input logic [7:0] imm);
    logic [11:0] r;
    if (ie) begin
      m_regs[dst] = imm;
      m_status[3] = imm[7];
      m_status[2] = (imm == 8'h00);
    end else if (code != 4'hF) begin
      r = fu_model(m_rd(sa), m_rd(sb), code);
      m_regs[dst] = r[11:4];
      m_status[3:2] = r[3:2];
      if (!code[3]) m_status[1:0] = r[1:0];
    end
`ifdef DP_REG0_ZERO_EN
    m_regs[0] = 8'h00;
`endif
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_reg(input logic [2:0] idx, input logic [7:0] exp);
    dbg_addr = idx;
    #1;
    chk($sformatf("reg[%0d]", idx), {24'd0, dbg_data}, {24'd0, exp});
  endtask

  // Issue one op from IDLE (called at posedge+1) and return at posedge+1 back in IDLE.
  task automatic do_op(input logic ie, input logic [3:0] code, input logic [2:0] dst,
                       input logic [2:0] sa, input logic [2:0] sb, input logic [7:0] imm);
    int lat;
    logic [7:0] ea, eb;
    ea = m_rd(sa); eb = m_rd(sb);
    op_imm_en = ie; op_code = code; op_dst = dst; op_srca = sa; op_srcb = sb; op_imm = imm;
    op_valid = 1'b1;
    chk("op_ready_idle", {31'd0, op_ready}, 32'd1);
    @(posedge clk); #1;
    op_valid = 1'b0;
    if (!ie) begin
      chk("fu_a", {24'd0, fu_a}, {24'd0, ea});
      chk("fu_b", {24'd0, fu_b}, {24'd0, eb});
      chk("fu_sel", {28'd0, fu_s2, fu_s1, fu_s0, fu_cin}, {28'd0, code});
    end
    lat = 1;
    while (!done && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, ie ? 32'd1 : 32'd2);
    chk("op_err", {31'd0, op_err}, {31'd0, (!ie && code == 4'hF)});
    @(posedge clk); #1;
    m_apply(ie, code, dst, sa, sb, imm);
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("status", {28'd0, status}, {28'd0, m_status});
    chk_reg(dst, m_regs[dst]);
  endtask

  typedef struct {
    logic       ie;
    logic [3:0] code;
    logic [2:0] dst, sa, sb;
    logic [7:0] imm;
    logic [7:0] exp_val;
    logic [3:0] exp_status;
  } vec_t;

  vec_t vt [7];
  int   accepts;

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{1'b1, 4'h0, 3'd1, 3'd0, 3'd0, 8'h7F, 8'h7F, 4'h0};
    vt[1] = '{1'b1, 4'h0, 3'd2, 3'd0, 3'd0, 8'h01, 8'h01, 4'h0};
    vt[2] = '{1'b0, 4'h2, 3'd3, 3'd1, 3'd2, 8'h00, 8'h80, 4'h9};
    vt[3] = '{1'b1, 4'h0, 3'd4, 3'd0, 3'd0, 8'hFF, 8'hFF, 4'h9};
    vt[4] = '{1'b0, 4'h1, 3'd5, 3'd4, 3'd1, 8'h00, 8'h00, 4'h6};
    vt[5] = '{1'b0, 4'h8, 3'd6, 3'd4, 3'd3, 8'h00, 8'h80, 4'hA};
    vt[6] = '{1'b0, 4'hF, 3'd1, 3'd2, 3'd2, 8'h00, 8'h7F, 4'hA};

    rst = 1'b1; op_valid = 1'b0; op_code = '0; op_dst = '0; op_srca = '0; op_srcb = '0;
    op_imm_en = 1'b0; op_imm = '0; dbg_addr = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, op_ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, op_err}, 32'd0);
    chk("rst_status", {28'd0, status}, 32'd0);
    chk("rst_fu_a", {24'd0, fu_a}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) chk_reg(3'(i), 8'h00);

    for (int i = 0; i < 7; i++) begin
      do_op(vt[i].ie, vt[i].code, vt[i].dst, vt[i].sa, vt[i].sb, vt[i].imm);
      chk($sformatf("vec%0d_val", i), {24'd0, dbg_data}, {24'd0, vt[i].exp_val});
      chk($sformatf("vec%0d_status", i), {28'd0, status}, {28'd0, vt[i].exp_status});
    end

    // op_valid held high: exactly one accept per IDLE visit.
    op_imm_en = 1'b0; op_code = 4'h0; op_dst = 3'd7; op_srca = 3'd1; op_srcb = 3'd2;
    op_valid = 1'b1;
    accepts = 0;
    for (int k = 0; k < 6; k++) begin
      chk("held_ready", {31'd0, op_ready}, {31'd0, (k % 3 == 0)});
      if (op_ready) accepts++;
      @(posedge clk); #1;
      chk("held_done", {31'd0, done}, {31'd0, (k % 3 == 1)});
    end
    op_valid = 1'b0;
    chk("held_accepts", accepts, 32'd2);
    m_apply(1'b0, 4'h0, 3'd7, 3'd1, 3'd2, 8'h00);
    m_apply(1'b0, 4'h0, 3'd7, 3'd1, 3'd2, 8'h00);
    chk("held_status", {28'd0, status}, {28'd0, m_status});
    chk_reg(3'd7, m_regs[7]);

    for (int i = 0; i < 40; i++) begin
      logic       ie;
      logic [3:0] code;
      ie = ($urandom_range(0, 3) == 0);
      code = 4'($urandom_range(0, 15));
      if (ie && code == 4'hF) code = 4'h0;
      do_op(ie, code, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 8'($urandom));
    end

    // Reset in EXEC aborts the op.
    op_imm_en = 1'b0; op_code = 4'h2; op_dst = 3'd3; op_srca = 3'd1; op_srcb = 3'd2;
    op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_ready", {31'd0, op_ready}, 32'd1);
    chk("abort_status", {28'd0, status}, 32'd0);
    chk("abort_fu_a", {24'd0, fu_a}, 32'd0);
    rst = 1'b0;
    m_reset();
    for (int i = 0; i < 8; i++) chk_reg(3'(i), 8'h00);
    @(posedge clk); #1;

    do_op(1'b1, 4'h0, 3'd0, 3'd0, 3'd0, 8'h55);
`ifdef DP_REG0_ZERO_EN
    chk("r0_zero", {24'd0, dbg_data}, 32'h00);
`else
    chk("r0_plain", {24'd0, dbg_data}, 32'h55);
`endif
    chk("r0_status", {28'd0, status}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
